// File: rtl/reg_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regacc_pkg
//  Description : Shared constants, FSM state encoding and ID helpers for the
//                register-block access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package regacc_pkg;

    // Width of a register ID as seen by the helper functions
    localparam int REGACC_ID_W = 4;

    // Architectural register map
    localparam logic [REGACC_ID_W-1:0] REG_ZERO = 4'd0;
    localparam logic [REGACC_ID_W-1:0] REG_CMP  = 4'd9;
    localparam logic [REGACC_ID_W-1:0] REG_SP   = 4'd10;
    localparam logic [REGACC_ID_W-1:0] REG_SF   = 4'd11;
    localparam logic [REGACC_ID_W-1:0] REG_PC   = 4'd12;
    localparam int                     NUM_REGS = 13;

    // Controller FSM state encoding
    typedef logic [1:0] regacc_state_t;
    localparam regacc_state_t S_IDLE = 2'd0;
    localparam regacc_state_t S_READ = 2'd1;
    localparam regacc_state_t S_HOLD = 2'd2;

    // True for IDs that have real storage and therefore a scoreboard bit.
    // Register 0 is hard-wired zero and IDs past the map are unimplemented.
    function automatic logic is_tracked(input logic [REGACC_ID_W-1:0] id);
        return (id != REG_ZERO) && (int'(id) < NUM_REGS);
    endfunction

endpackage : regacc_pkg
`default_nettype wire

// File: rtl/reg_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_access_ctrl_if
//  Description : Bundles the fetch-request, operand, writeback and register
//                block port signals of the access controller.
//                slave  = controller side, master = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_access_ctrl_if #(
    parameter int DATA_W   = 8,
    parameter int ID_W     = 4,
    parameter int NUM_REGS = 13
);
    // Fetch request
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_src1;
    logic [ID_W-1:0]   req_src2;
    logic [ID_W-1:0]   req_dst;
    logic              req_dst_en;
    // Register block read ports
    logic [ID_W-1:0]   read1_id;
    logic [DATA_W-1:0] read1_value;
    logic [ID_W-1:0]   read2_id;
    logic [DATA_W-1:0] read2_value;
    // Operand handoff
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ID_W-1:0]   op_dst;
    logic              op_dst_en;
    // Writeback and register block write port
    logic              wb_valid;
    logic              wb_ready;
    logic [ID_W-1:0]   wb_id;
    logic [DATA_W-1:0] wb_value;
    logic [ID_W-1:0]   write_id;
    logic [DATA_W-1:0] write_value;
    // Scoreboard view
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  req_valid, req_src1, req_src2, req_dst, req_dst_en,
        input  read1_value, read2_value, op_ready,
        input  wb_valid, wb_id, wb_value,
        output req_ready, read1_id, read2_id,
        output op_valid, op_a, op_b, op_dst, op_dst_en,
        output wb_ready, write_id, write_value, pending
    );

    modport master (
        output req_valid, req_src1, req_src2, req_dst, req_dst_en,
        output read1_value, read2_value, op_ready,
        output wb_valid, wb_id, wb_value,
        input  req_ready, read1_id, read2_id,
        input  op_valid, op_a, op_b, op_dst, op_dst_en,
        input  wb_ready, write_id, write_value, pending
    );

endinterface : reg_access_ctrl_if
`default_nettype wire

// File: rtl/reg_access_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register pending-write bits with one set and one clear
//                port and combinational lookup for three IDs. Bit 0 and IDs
//                beyond the register map never report pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int ID_W     = 4,
    parameter int NUM_REGS = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set_en,
    input  logic [ID_W-1:0]     i_set_id,
    input  logic                i_clr_en,
    input  logic [ID_W-1:0]     i_clr_id,
    input  logic [ID_W-1:0]     i_src1_id,
    input  logic [ID_W-1:0]     i_src2_id,
    input  logic [ID_W-1:0]     i_dst_id,
    output logic                o_src1_pend,
    output logic                o_src2_pend,
    output logic                o_dst_pend,
    output logic [NUM_REGS-1:0] o_pending
);
    import regacc_pkg::*;

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Looks up one ID; starting the scan at 1 keeps register 0 hazard-free
    // and unmatched (unimplemented) IDs fall through as not pending.
    function automatic logic lookup(input logic [ID_W-1:0]     id,
                                    input logic [NUM_REGS-1:0] vec);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (id == ID_W'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // Decode set/clear requests into one-hot masks
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_set_mask[i] = i_set_en && (i_set_id == ID_W'(i));
            w_clr_mask[i] = i_clr_en && (i_clr_id == ID_W'(i));
        end
    end

    // Pending bits: clear first, then set, so a coincident set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_src1_pend = lookup(i_src1_id, r_pending);
    assign o_src2_pend = lookup(i_src2_id, r_pending);
    assign o_dst_pend  = lookup(i_dst_id,  r_pending);
    assign o_pending   = r_pending;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_access_ctrl
//  Description : Initiator side of the register block. Accepts operand-fetch
//                requests, drives both read-ID ports, returns the operands
//                over valid/ready, pulses writebacks onto the write port and
//                stalls RAW/WAW hazards using a pending scoreboard.
//                Optional macro REGACC_BYPASS_EN forwards a same-cycle
//                writeback into a stalled source instead of stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_access_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ID_W     = 4,
    parameter int NUM_REGS = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_access_ctrl_if.slave bus
);
    import regacc_pkg::*;

    regacc_state_t       r_state;
    logic [ID_W-1:0]     r_read1_id;
    logic [ID_W-1:0]     r_read2_id;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [ID_W-1:0]     r_op_dst;
    logic                r_op_dst_en;
    logic                r_op_valid;
    logic [ID_W-1:0]     r_write_id;
    logic [DATA_W-1:0]   r_write_value;

    logic                w_src1_pend;
    logic                w_src2_pend;
    logic                w_dst_pend;
    logic [NUM_REGS-1:0] w_pending;
    logic                w_haz1;
    logic                w_haz2;
    logic                w_hazard;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_set_en;
    logic                w_clr_en;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;

    reg_scoreboard #(
        .ID_W     (ID_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_en    (w_set_en),
        .i_set_id    (bus.req_dst),
        .i_clr_en    (w_clr_en),
        .i_clr_id    (bus.wb_id),
        .i_src1_id   (bus.req_src1),
        .i_src2_id   (bus.req_src2),
        .i_dst_id    (bus.req_dst),
        .o_src1_pend (w_src1_pend),
        .o_src2_pend (w_src2_pend),
        .o_dst_pend  (w_dst_pend),
        .o_pending   (w_pending)
    );

`ifdef REGACC_BYPASS_EN
    logic              w_byp1;
    logic              w_byp2;
    logic              r_byp1;
    logic              r_byp2;
    logic [DATA_W-1:0] r_byp_value;

    // A source matching the writeback in flight this cycle takes its value
    // from that writeback, since the block is only updated after READ.
    assign w_byp1 = bus.wb_valid && is_tracked(bus.req_src1) && (bus.wb_id == bus.req_src1);
    assign w_byp2 = bus.wb_valid && is_tracked(bus.req_src2) && (bus.wb_id == bus.req_src2);
    assign w_haz1 = w_src1_pend && !w_byp1;
    assign w_haz2 = w_src2_pend && !w_byp2;

    // Remember which operands are forwarded and the forwarded value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp1      <= 1'b0;
            r_byp2      <= 1'b0;
            r_byp_value <= '0;
        end else if (w_accept) begin
            r_byp1      <= w_byp1;
            r_byp2      <= w_byp2;
            r_byp_value <= bus.wb_value;
        end
    end

    assign w_rd_a = r_byp1 ? r_byp_value : bus.read1_value;
    assign w_rd_b = r_byp2 ? r_byp_value : bus.read2_value;
`else
    // Without forwarding, a clear in this cycle is only seen next cycle.
    assign w_haz1 = w_src1_pend;
    assign w_haz2 = w_src2_pend;
    assign w_rd_a = bus.read1_value;
    assign w_rd_b = bus.read2_value;
`endif

    // WAW check applies in both builds
    assign w_hazard    = w_haz1 || w_haz2 || (bus.req_dst_en && w_dst_pend);
    assign w_req_ready = (r_state == S_IDLE) && !w_hazard;
    assign w_accept    = w_req_ready && bus.req_valid;
    assign w_set_en    = w_accept && bus.req_dst_en && is_tracked(bus.req_dst);
    assign w_clr_en    = bus.wb_valid && is_tracked(bus.wb_id);

    // Fetch sequencer: IDLE accepts, READ samples the block, HOLD hands off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_read1_id  <= '0;
            r_read2_id  <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_dst    <= '0;
            r_op_dst_en <= 1'b0;
            r_op_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_read1_id  <= bus.req_src1;
                        r_read2_id  <= bus.req_src2;
                        r_op_dst    <= bus.req_dst;
                        r_op_dst_en <= bus.req_dst_en;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_op_a     <= w_rd_a;
                    r_op_b     <= w_rd_b;
                    r_op_valid <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_op_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Write port: one-cycle pulse per writeback, parked at register 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_id    <= '0;
            r_write_value <= '0;
        end else if (bus.wb_valid) begin
            r_write_id    <= bus.wb_id;
            r_write_value <= bus.wb_value;
        end else begin
            r_write_id    <= '0;
            r_write_value <= '0;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.read1_id    = r_read1_id;
    assign bus.read2_id    = r_read2_id;
    assign bus.op_valid    = r_op_valid;
    assign bus.op_a        = r_op_a;
    assign bus.op_b        = r_op_b;
    assign bus.op_dst      = r_op_dst;
    assign bus.op_dst_en   = r_op_dst_en;
    assign bus.wb_ready    = 1'b1;
    assign bus.write_id    = r_write_id;
    assign bus.write_value = r_write_value;
    assign bus.pending     = w_pending;

endmodule : reg_access_ctrl
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_access_ctrl
//  Description : Self-checking bench for reg_access_ctrl with a behavioural
//                13-entry register block attached to the read/write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_access_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

`ifdef REGACC_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    reg_access_ctrl_if #(.DATA_W(8), .ID_W(4), .NUM_REGS(13)) bus ();

    reg_access_ctrl #(.DATA_W(8), .ID_W(4), .NUM_REGS(13)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register block: IDs 0 and 13..15 read as zero, writes ignored
    logic [7:0] mem [16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bus.write_id != 4'd0 && bus.write_id < 4'd13) begin
            mem[bus.write_id] <= bus.write_value;
        end
    end
    assign bus.read1_value = (bus.read1_id == 4'd0 || bus.read1_id >= 4'd13) ? 8'h00 : mem[bus.read1_id];
    assign bus.read2_value = (bus.read2_id == 4'd0 || bus.read2_id >= 4'd13) ? 8'h00 : mem[bus.read2_id];

    typedef struct {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] d;
        logic       den;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] s1, input logic [3:0] s2,
                             input logic [3:0] d, input logic den);
        bus.req_valid  = 1'b1;
        bus.req_src1   = s1;
        bus.req_src2   = s2;
        bus.req_dst    = d;
        bus.req_dst_en = den;
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid  = 1'b0;
        bus.req_src1   = 4'd0;
        bus.req_src2   = 4'd0;
        bus.req_dst    = 4'd0;
        bus.req_dst_en = 1'b0;
    endtask

    // Waits (bounded) for req_ready, then takes the accept edge; returns in READ
    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        clear_req();
    endtask

    // Called in READ with op_ready high: checks latency, operands and release
    task automatic finish_fetch(input string nm, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] d, input logic den);
        chk({nm, " op_valid in READ"}, 32'(bus.op_valid), 32'd0);
        tick();
        chk({nm, " op_valid"},  32'(bus.op_valid),  32'd1);
        chk({nm, " op_a"},      32'(bus.op_a),      32'(a));
        chk({nm, " op_b"},      32'(bus.op_b),      32'(b));
        chk({nm, " op_dst"},    32'(bus.op_dst),    32'(d));
        chk({nm, " op_dst_en"}, 32'(bus.op_dst_en), 32'(den));
        tick();
        chk({nm, " op_valid drop"}, 32'(bus.op_valid),  32'd0);
        chk({nm, " idle ready"},    32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_wb(input logic [3:0] id, input logic [7:0] val);
        bus.wb_valid = 1'b1;
        bus.wb_id    = id;
        bus.wb_value = val;
        tick();
        bus.wb_valid = 1'b0;
        bus.wb_id    = 4'd0;
        bus.wb_value = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        //          s1     s2     d      den   a      b
        vecs[0] = '{4'd3,  4'd7,  4'd0,  1'b0, 8'h5A, 8'hC3};
        vecs[1] = '{4'd7,  4'd3,  4'd0,  1'b1, 8'hC3, 8'h5A};
        vecs[2] = '{4'd12, 4'd9,  4'd14, 1'b1, 8'hA5, 8'h3C};
        vecs[3] = '{4'd0,  4'd5,  4'd0,  1'b0, 8'h00, 8'h77};
        vecs[4] = '{4'd14, 4'd1,  4'd15, 1'b0, 8'h00, 8'h01};
        vecs[5] = '{4'd1,  4'd1,  4'd6,  1'b0, 8'h01, 8'h01};

        rst_n        = 1'b0;
        clear_req();
        bus.op_ready = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_id    = 4'd0;
        bus.wb_value = 8'd0;

        // Reset state
        repeat (3) tick();
        chk("rst op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst pending",  32'(bus.pending),  32'd0);
        chk("rst write_id", 32'(bus.write_id), 32'd0);
        chk("rst read1_id", 32'(bus.read1_id), 32'd0);
        chk("rst op_a",     32'(bus.op_a),     32'd0);
        rst_n = 1'b1;
        tick();
        chk("post-rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("wb_ready",           32'(bus.wb_ready),  32'd1);

        // Back-to-back writebacks give consecutive one-cycle pulses
        bus.wb_valid = 1'b1; bus.wb_id = 4'd3; bus.wb_value = 8'h5A;
        tick();
        chk("wb pulse1 id",  32'(bus.write_id),    32'd3);
        chk("wb pulse1 val", 32'(bus.write_value), 32'h5A);
        bus.wb_id = 4'd7; bus.wb_value = 8'hC3;
        tick();
        chk("wb pulse2 id",  32'(bus.write_id),    32'd7);
        chk("wb pulse2 val", 32'(bus.write_value), 32'hC3);
        bus.wb_valid = 1'b0; bus.wb_id = 4'd0; bus.wb_value = 8'd0;
        tick();
        chk("wb idle id", 32'(bus.write_id), 32'd0);
        do_wb(4'd12, 8'hA5);
        do_wb(4'd9,  8'h3C);
        do_wb(4'd5,  8'h77);
        do_wb(4'd1,  8'h01);
        chk("preload pending", 32'(bus.pending), 32'd0);

        // Writes to register 0 and an unimplemented ID
        bus.wb_valid = 1'b1; bus.wb_id = 4'd0; bus.wb_value = 8'hFF;
        tick();
        chk("wb0 write_id",    32'(bus.write_id),    32'd0);
        chk("wb0 write_value", 32'(bus.write_value), 32'hFF);
        chk("wb0 pending",     32'(bus.pending),     32'd0);
        bus.wb_id = 4'd14; bus.wb_value = 8'hEE;
        tick();
        chk("wb14 write_id", 32'(bus.write_id), 32'd14);
        chk("wb14 pending",  32'(bus.pending),  32'd0);
        bus.wb_valid = 1'b0; bus.wb_id = 4'd0; bus.wb_value = 8'd0;
        tick();

        // Table-driven fetches
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].den);
            wait_accept($sformatf("vec%0d", i));
            finish_fetch($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].den);
            chk($sformatf("vec%0d pending", i), 32'(bus.pending), 32'd0);
        end

        // RAW: dst=4 outstanding, then a read of r4 waits for its writeback
        drive_req(4'd1, 4'd0, 4'd4, 1'b1);
        wait_accept("raw set");
        chk("raw pending set", 32'(bus.pending), 32'h0010);
        finish_fetch("raw set", 8'h01, 8'h00, 4'd4, 1'b1);
        drive_req(4'd4, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("raw stall%0d", k), 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.wb_valid = 1'b1; bus.wb_id = 4'd4; bus.wb_value = 8'h11;
        #1;
        chk("raw same-cycle ready", 32'(bus.req_ready), 32'(BYPASS));
        tick();
        bus.wb_valid = 1'b0; bus.wb_id = 4'd0; bus.wb_value = 8'd0;
        chk("raw pending clear", 32'(bus.pending), 32'd0);
        if (BYPASS) begin
            clear_req();
        end else begin
            wait_accept("raw read");
        end
        finish_fetch("raw read", 8'h11, 8'h00, 4'd0, 1'b0);

        // Downstream stall: operands held, no new request accepted
        bus.op_ready = 1'b0;
        drive_req(4'd3, 4'd7, 4'd0, 1'b0);
        wait_accept("stall");
        tick();
        drive_req(4'd1, 4'd1, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d op_valid", k), 32'(bus.op_valid),  32'd1);
            chk($sformatf("stall%0d op_a", k),     32'(bus.op_a),      32'h5A);
            chk($sformatf("stall%0d op_b", k),     32'(bus.op_b),      32'hC3);
            chk($sformatf("stall%0d ready", k),    32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.op_ready = 1'b1;
        tick();
        chk("stall release op_valid", 32'(bus.op_valid),  32'd0);
        chk("stall release ready",    32'(bus.req_ready), 32'd1);
        tick();
        clear_req();
        finish_fetch("post-stall", 8'h01, 8'h01, 4'd0, 1'b0);

        // WAW on PC
        drive_req(4'd0, 4'd0, 4'd12, 1'b1);
        wait_accept("waw first");
        finish_fetch("waw first", 8'h00, 8'h00, 4'd12, 1'b1);
        chk("waw pending set", 32'(bus.pending), 32'h1000);
        drive_req(4'd0, 4'd0, 4'd12, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("waw stall%0d", k), 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.wb_valid = 1'b1; bus.wb_id = 4'd12; bus.wb_value = 8'h42;
        #1;
        chk("waw same-cycle ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.wb_valid = 1'b0; bus.wb_id = 4'd0; bus.wb_value = 8'd0;
        chk("waw pending clear", 32'(bus.pending), 32'd0);
        wait_accept("waw second");
        chk("waw pending reset", 32'(bus.pending), 32'h1000);
        finish_fetch("waw second", 8'h00, 8'h00, 4'd12, 1'b1);
        do_wb(4'd12, 8'h43);
        chk("waw final pending", 32'(bus.pending), 32'd0);

        // Asynchronous reset in READ with a pending bit and a live write pulse
        drive_req(4'd0, 4'd0, 4'd5, 1'b1);
        wait_accept("rst setup");
        finish_fetch("rst setup", 8'h00, 8'h00, 4'd5, 1'b1);
        drive_req(4'd3, 4'd0, 4'd0, 1'b0);
        bus.wb_valid = 1'b1; bus.wb_id = 4'd9; bus.wb_value = 8'h99;
        wait_accept("rst read");
        bus.wb_valid = 1'b0; bus.wb_id = 4'd0; bus.wb_value = 8'd0;
        chk("pre-rst write_id", 32'(bus.write_id), 32'd9);
        chk("pre-rst pending",  32'(bus.pending),  32'h0020);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst op_valid", 32'(bus.op_valid), 32'd0);
        chk("async rst pending",  32'(bus.pending),  32'd0);
        chk("async rst write_id", 32'(bus.write_id), 32'd0);
        chk("async rst read1_id", 32'(bus.read1_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after rst ready",    32'(bus.req_ready), 32'd1);
        tick();
        chk("after rst op_valid", 32'(bus.op_valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_access_ctrl
`default_nettype wire
